prep3_fsm_param: RTL and testbench
==================================

Name: prep3_fsm_param

Overview:
- Parametrised successor of the team's 8-state PREP3 benchmark controller.
- Same key-driven state graph as PREP3, extended in four ways:
  - data width is a parameter;
  - the FSM advances only on qualified input beats;
  - a configurable dwell timeout applies in state SA;
  - completed-sequence counting is available as an option.
- Used as a control-path benchmark and a reusable command-sequence decoder inside the prep benchmark suite.

Parameters:
- WIDTH, 8: IN/OUT data width. Legal range is 8 or more; elaboration error if less than 8.
- KEY_GO, 8'h3c: key for START->SA. Zero-extended to WIDTH.
- KEY_C, 8'h2a: key for SA->SC. Zero-extended to WIDTH.
- KEY_B, 8'h1f: key for SA->SB. Zero-extended to WIDTH.
- KEY_E, 8'haa: key for SB->SE. Zero-extended to WIDTH.
- SA_TIMEOUT, 0: number of consecutive non-matching valid beats in SA before forced return to START. 0 disables the timeout.
- CNT_W, 16: width of SEQ_CNT.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: reset.
- IN_VALID, input, 1: qualifies IN. The FSM evaluates only when IN_VALID is 1.
- IN, input, WIDTH: command/data word.
- OUT, output, WIDTH: registered Mealy output code, zero-extended from 8 bits.
- OUT_VALID, output, 1: registered copy of IN_VALID.
- STATE, output, 8: one-hot current state. Bit order is START=0, SA=1, SB=2, SC=3, SD=4, SE=5, SF=6, SG=7.
- TIMEOUT_PULSE, output, 1: single-cycle flag marking an SA timeout exit.
- SEQ_CNT, output, CNT_W: count of completed sequences.

Interface rule: reset RST, asynchronous, active-high; clock CLK.

Behaviour:
- Reset values:
  - STATE = START (8'h01);
  - OUT = 0, OUT_VALID = 0, TIMEOUT_PULSE = 0, SEQ_CNT = 0;
  - SA dwell counter = 0.
- Reset mid-sequence aborts immediately (asynchronous). No state is retained.
- Latency: the state and OUT update on the CLK edge that samples IN_VALID=1. OUT_VALID is high in that same following cycle.
- IN_VALID=0: STATE, OUT, dwell counter and SEQ_CNT hold. OUT_VALID=0 and TIMEOUT_PULSE=0.
- Transitions on a valid beat, giving next state and OUT:
  - START: IN==KEY_GO -> SA, 82. Otherwise -> START, 00.
  - SA: IN==KEY_C -> SC, 40. Else IN==KEY_B -> SB, 20. Else -> SA, 04 (subject to the timeout rule below).
  - SB: IN==KEY_E -> SE, 11. Otherwise -> SF, 30.
  - SC -> SD, 08 (unconditional).
  - SD -> SG, 80 (unconditional).
  - SE -> START, 40 (unconditional).
  - SF -> SG, 02 (unconditional).
  - SG -> START, 01 (unconditional).
- Key priority: KEY_C is checked before KEY_B. If the parameters make them equal, SC wins.
- Key compare uses the full WIDTH. Upper IN bits must be zero to match.
- SA timeout (SA_TIMEOUT > 0):
  - The dwell counter counts consecutive valid "stay" beats in SA. It has clog2(SA_TIMEOUT+1) bits.
  - On the SA_TIMEOUT-th consecutive stay beat the FSM goes SA->START instead: OUT=00 and TIMEOUT_PULSE=1 for exactly that one cycle.
  - A KEY_C or KEY_B match on that beat wins over the timeout.
  - The counter clears on any exit from SA and on entry to SA.
  - Invalid beats (IN_VALID=0) neither count nor clear the counter.
- Illegal state encoding (not one-hot): recover to START with OUT=00 on the next valid beat. There is no X propagation.
- Registers are updated with non-blocking assignments only.

Optional Feature:
- Macro: PREP3_SEQ_CNT_EN.
- Defined:
  - SEQ_CNT increments by 1 on every valid beat that takes SG->START.
  - Wraps modulo 2^CNT_W with no saturation.
  - SE->START and timeout exits do not count.
- Undefined: SEQ_CNT is tied to 0 and the counter logic is absent.

Decomposition:
- Package prep3_pkg holds:
  - state index localparams (START..SG) and the 8-bit output code constants;
  - a clog2 helper function.
- One sub-module: prep3_dwell_cnt, the SA dwell counter with its clear/increment/terminal-count logic. It is instantiated only when SA_TIMEOUT > 0 (generate block).

Test Plan:
- Reset, then IN=3c valid -> OUT=82, STATE=02, OUT_VALID=1. Next, IN=2a -> OUT=40, STATE=08. Then two valid beats -> OUT=08 then 80 (SD, SG). Then one valid beat -> OUT=01, STATE=01, and SEQ_CNT=1 with the macro defined.
- Path START->SA->SB with IN=aa -> OUT=11, then START with OUT=40, and SEQ_CNT unchanged. Repeat with IN=55 at SB -> SF (OUT=30), then SG (02), then START (01).
- IN_VALID=0 for 5 cycles while in SB with IN=aa held -> STATE stays 04, OUT holds 20, OUT_VALID=0.
- SA_TIMEOUT=3, in SA, IN=00 valid for 3 beats -> OUT=04, 04, then 00 with STATE=01 and TIMEOUT_PULSE high for one cycle. Repeat with IN=1f on the third beat -> SB, OUT=20, no pulse.
- Assert RST asynchronously mid-edge while in SD -> all outputs reach reset values before the next CLK edge. Then IN=3c -> OUT=82.
- WIDTH=16, macro defined, CNT_W=2: IN=16'h013c does not match (STATE stays START). Run 5 full sequences -> SEQ_CNT=1 (wrap).

Source files
------------

// File: rtl/prep3_pkg.sv
// prep3_pkg: shared state indices, one-hot state type, 8-bit output codes
// and a constant clog2 helper for the PREP3 command-sequence decoder.
package prep3_pkg;

  // Bit positions of each state inside the one-hot STATE vector
  localparam int S_START = 0;
  localparam int S_SA    = 1;
  localparam int S_SB    = 2;
  localparam int S_SC    = 3;
  localparam int S_SD    = 4;
  localparam int S_SE    = 5;
  localparam int S_SF    = 6;
  localparam int S_SG    = 7;

  typedef enum logic [7:0] {
    ST_START = 8'h01 << S_START,
    ST_SA    = 8'h01 << S_SA,
    ST_SB    = 8'h01 << S_SB,
    ST_SC    = 8'h01 << S_SC,
    ST_SD    = 8'h01 << S_SD,
    ST_SE    = 8'h01 << S_SE,
    ST_SF    = 8'h01 << S_SF,
    ST_SG    = 8'h01 << S_SG
  } state_t;

  // Mealy output codes, named by value
  localparam logic [7:0] OC_00 = 8'h00;
  localparam logic [7:0] OC_01 = 8'h01;
  localparam logic [7:0] OC_02 = 8'h02;
  localparam logic [7:0] OC_04 = 8'h04;
  localparam logic [7:0] OC_08 = 8'h08;
  localparam logic [7:0] OC_11 = 8'h11;
  localparam logic [7:0] OC_20 = 8'h20;
  localparam logic [7:0] OC_30 = 8'h30;
  localparam logic [7:0] OC_40 = 8'h40;
  localparam logic [7:0] OC_80 = 8'h80;
  localparam logic [7:0] OC_82 = 8'h82;

  // Smallest r with 2**r >= v (at least 1 so it can size a vector)
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prep3_dwell_cnt.sv
// prep3_dwell_cnt: counts consecutive valid "stay" beats spent in SA and
// flags the beat that reaches LIMIT. Cleared on any other valid beat.
module prep3_dwell_cnt
  import prep3_pkg::*;
#(
  parameter int LIMIT = 1,
  parameter int W     = clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic stay,   // valid beat in SA with no key match
  input  logic clr,    // valid beat that is not a stay (entry/exit/other)
  output logic tc      // this stay beat is the LIMIT-th in a row
);

  logic [W-1:0] cnt;

  // cnt holds the number of stays already seen, so the LIMIT-th stay sees LIMIT-1
  assign tc = (cnt == W'(LIMIT - 1));

  // Count stays; a terminal stay exits SA, so it clears like any exit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   cnt <= '0;
    else if (clr || (stay && tc)) cnt <= '0;
    else if (stay)             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/prep3_fsm_param.sv
// prep3_fsm_param: parametrised PREP3 key-driven 8-state controller.
// Advances only on IN_VALID beats, optional SA dwell timeout (SA_TIMEOUT>0),
// optional completed-sequence counter under macro PREP3_SEQ_CNT_EN.
module prep3_fsm_param
  import prep3_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [7:0] KEY_GO     = 8'h3c,
  parameter logic [7:0] KEY_C      = 8'h2a,
  parameter logic [7:0] KEY_B      = 8'h1f,
  parameter logic [7:0] KEY_E      = 8'haa,
  parameter int         SA_TIMEOUT = 0,
  parameter int         CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  output logic [7:0]       STATE,
  output logic             TIMEOUT_PULSE,
  output logic [CNT_W-1:0] SEQ_CNT
);

  if (WIDTH < 8) begin : g_bad_width
    $error("prep3_fsm_param: WIDTH must be 8 or more");
  end

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       pulse_q, pulse_d;
  logic       ovalid_q;
  logic       hit_go, hit_c, hit_b, hit_e;
  logic       sa_stay, dwell_tc;

  // Full-width compare: keys are zero-extended, so upper IN bits must be 0
  assign hit_go = (IN == WIDTH'(KEY_GO));
  assign hit_c  = (IN == WIDTH'(KEY_C));
  assign hit_b  = (IN == WIDTH'(KEY_B));
  assign hit_e  = (IN == WIDTH'(KEY_E));

  assign sa_stay = IN_VALID && (state_q == ST_SA) && !hit_c && !hit_b;

  if (SA_TIMEOUT > 0) begin : g_dwell
    prep3_dwell_cnt #(.LIMIT(SA_TIMEOUT)) u_dwell (
      .CLK  (CLK),
      .RST  (RST),
      .stay (sa_stay),
      .clr  (IN_VALID && !sa_stay),
      .tc   (dwell_tc)
    );
  end else begin : g_no_dwell
    assign dwell_tc = 1'b0;
  end

  // Next state and Mealy code; nothing moves without a valid beat
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    if (IN_VALID) begin
      case (state_q)
        ST_START: begin
          if (hit_go) begin state_d = ST_SA;    code_d = OC_82; end
          else        begin state_d = ST_START; code_d = OC_00; end
        end
        ST_SA: begin
          if (hit_c)         begin state_d = ST_SC;    code_d = OC_40; end
          else if (hit_b)    begin state_d = ST_SB;    code_d = OC_20; end
          else if (dwell_tc) begin state_d = ST_START; code_d = OC_00; pulse_d = 1'b1; end
          else               begin state_d = ST_SA;    code_d = OC_04; end
        end
        ST_SB: begin
          if (hit_e) begin state_d = ST_SE; code_d = OC_11; end
          else       begin state_d = ST_SF; code_d = OC_30; end
        end
        ST_SC:   begin state_d = ST_SD;    code_d = OC_08; end
        ST_SD:   begin state_d = ST_SG;    code_d = OC_80; end
        ST_SE:   begin state_d = ST_START; code_d = OC_40; end
        ST_SF:   begin state_d = ST_SG;    code_d = OC_02; end
        ST_SG:   begin state_d = ST_START; code_d = OC_01; end
        // Non-one-hot encodings fall back to START
        default: begin state_d = ST_START; code_d = OC_00; end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_START;
      code_q   <= OC_00;
      pulse_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      pulse_q  <= pulse_d;
      ovalid_q <= IN_VALID;
    end
  end

  assign STATE         = state_q;
  assign OUT           = WIDTH'(code_q);
  assign OUT_VALID     = ovalid_q;
  assign TIMEOUT_PULSE = pulse_q;

`ifdef PREP3_SEQ_CNT_EN
  logic [CNT_W-1:0] seq_q;

  // Count only SG->START completions; wraps freely
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              seq_q <= '0;
    else if (IN_VALID && state_q == ST_SG) seq_q <= seq_q + 1'b1;
  end

  assign SEQ_CNT = seq_q;
`else
  assign SEQ_CNT = '0;
`endif

endmodule

// File: tb/tb_prep3_fsm_param.sv
// tb_prep3_fsm_param: random + directed stimulus against a behavioural
// reference model; expected responses are queued and checked by a monitor.
module tb_prep3_fsm_param;

  localparam int WIDTH = 16;
  localparam int SA_TO = 3;
  localparam int CNT_W = 2;
  localparam logic [15:0] KGO = 16'h003c;
  localparam logic [15:0] KC  = 16'h002a;
  localparam logic [15:0] KB  = 16'h001f;
  localparam logic [15:0] KE  = 16'h00aa;
`ifdef PREP3_SEQ_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             CLK, RST, IN_VALID;
  logic [WIDTH-1:0] IN, OUT;
  logic             OUT_VALID, TIMEOUT_PULSE;
  logic [7:0]       STATE;
  logic [CNT_W-1:0] SEQ_CNT;

  prep3_fsm_param #(.WIDTH(WIDTH), .SA_TIMEOUT(SA_TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN(IN), .OUT(OUT),
    .OUT_VALID(OUT_VALID), .STATE(STATE), .TIMEOUT_PULSE(TIMEOUT_PULSE),
    .SEQ_CNT(SEQ_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] out;
    logic        ov;
    logic [7:0]  st;
    logic        pl;
    logic [1:0]  seq;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: state named by position in "START SA SB SC SD SE SF SG"
  typedef enum int {M_START, M_SA, M_SB, M_SC, M_SD, M_SE, M_SF, M_SG} mst_t;
  mst_t        m_st;
  logic [15:0] m_out;
  int          m_dwell;
  int          m_seq;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_START; m_out = 16'h0; m_dwell = 0; m_seq = 0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".state"}, 32'(STATE), 32'h01);
    chk({tag, ".out"}, 32'(OUT), 32'h0);
    chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'h0);
    chk({tag, ".pulse"}, 32'(TIMEOUT_PULSE), 32'h0);
    chk({tag, ".seq_cnt"}, 32'(SEQ_CNT), 32'h0);
  endtask

  // Drive one beat at the falling edge and queue what the next rising edge must produce
  task automatic beat(bit v, logic [15:0] d);
    exp_t e;
    bit   pulse;
    @(negedge CLK);
    IN_VALID = v;
    IN       = d;
    pulse    = 1'b0;
    if (v) begin
      case (m_st)
        M_START: if (d == KGO) begin m_st = M_SA; m_out = 16'h82; end
                 else          begin m_st = M_START; m_out = 16'h00; end
        M_SA: begin
          if (d == KC)      begin m_st = M_SC; m_out = 16'h40; end
          else if (d == KB) begin m_st = M_SB; m_out = 16'h20; end
          else begin
            m_dwell++;
            if (SA_TO > 0 && m_dwell == SA_TO) begin
              m_st = M_START; m_out = 16'h00; pulse = 1'b1;
            end else m_out = 16'h04;
          end
        end
        M_SB: if (d == KE) begin m_st = M_SE; m_out = 16'h11; end
              else         begin m_st = M_SF; m_out = 16'h30; end
        M_SC: begin m_st = M_SD; m_out = 16'h08; end
        M_SD: begin m_st = M_SG; m_out = 16'h80; end
        M_SE: begin m_st = M_START; m_out = 16'h40; end
        M_SF: begin m_st = M_SG; m_out = 16'h02; end
        M_SG: begin
          m_st = M_START; m_out = 16'h01;
          if (CNT_ON) m_seq = (m_seq + 1) % (1 << CNT_W);
        end
        default: ;
      endcase
      if (m_st != M_SA) m_dwell = 0;
    end
    e.out = m_out;
    e.ov  = v;
    e.st  = 8'(1 << int'(m_st));
    e.pl  = pulse;
    e.seq = 2'(m_seq);
    q.push_back(e);
  endtask

  // Asynchronous reset just after a rising edge, checked before the next one
  task automatic mid_reset(string tag);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    IN_VALID = 1'b0;
    #1;
    chk_reset(tag);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic full_seq();
    beat(1, KGO); beat(1, KC); beat(1, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
  endtask

  // Monitor: every rising edge that follows a queued beat is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", 32'(OUT), 32'(e.out));
        chk("out_valid", 32'(OUT_VALID), 32'(e.ov));
        chk("state", 32'(STATE), 32'(e.st));
        chk("pulse", 32'(TIMEOUT_PULSE), 32'(e.pl));
        chk("seq_cnt", 32'(SEQ_CNT), 32'(e.seq));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk_reset("reset");
    RST = 1'b0;

    // Main sequence START-SA-SC-SD-SG-START
    full_seq();
    // SA->SB->SE->START, then SB->SF->SG->START
    beat(1, KGO); beat(1, KB); beat(1, KE); beat(1, 16'h0);
    beat(1, KGO); beat(1, KB); beat(1, 16'h0055); beat(1, 16'h0); beat(1, 16'h0);
    // Hold in SB with IN_VALID low
    beat(1, KGO); beat(1, KB);
    repeat (5) beat(0, KE);
    beat(1, KE); beat(1, 16'h0);
    // SA timeout, key on terminal beat, invalid beats inside the dwell
    beat(1, KGO); beat(1, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
    beat(1, KGO); beat(1, 16'h0); beat(1, 16'h0); beat(1, KB);
    beat(1, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
    beat(1, KGO); beat(1, 16'h0); beat(0, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
    beat(1, KGO); beat(1, 16'h0); beat(1, 16'h0); beat(1, KC);
    beat(1, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
    // Reset while in SD, then restart
    beat(1, KGO); beat(1, KC); beat(1, 16'h0);
    mid_reset("mid_reset_sd");
    beat(1, KGO); beat(1, KC); beat(1, 16'h0); beat(1, 16'h0); beat(1, 16'h0);
    // Upper bits block a match; five sequences wrap a 2-bit counter
    beat(1, 16'h013c); beat(1, 16'h012a);
    repeat (5) full_seq();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      bit          v;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: d = KGO;
        1: d = KC;
        2: d = KB;
        3: d = KE;
        4: d = KGO | (16'h0100 << $urandom_range(0, 7));
        default: d = 16'($urandom);
      endcase
      beat(v, d);
      if (i % 700 == 699) mid_reset("mid_reset_rand");
    end

    repeat (3) beat(0, 16'h0);
    @(posedge CLK);
    #2;
    chk("drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
